// File: rtl/sig_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sig_bus_arbiter
//
// Round-robin arbiter that shares one registered WIDTH-bit data path among
// N_REQ producers. A grant stays with one producer for at most MAX_BURST
// accepted beats, then rotates. Beats leave on a single registered output
// stream with a valid/ready handshake. Full throughput of one beat per cycle
// is possible because a new beat may be taken in the same cycle the previous
// one is consumed.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous reset, active-high, highest priority
//   req        in   [N_REQ]        per-requester request, held until accepted
//   req_data   in   [N_REQ*WIDTH]  slice i = req_data[i*WIDTH +: WIDTH]
//   gnt        out  [N_REQ]        registered one-hot grant, zero when idle
//   accept     out  [N_REQ]        combinational one-hot "beat taken" pulse
//   out_data   out  [WIDTH]        registered output data
//   out_valid  out                 out_data holds an unconsumed beat
//   out_ready  in                  consumer takes out_data when out_valid=1
// -----------------------------------------------------------------------------

// Invariant monitor: grant is zero/one-hot, accept is inside grant, and the
// burst counter never passes its limit.
module sig_bus_arbiter_chk #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [N_REQ-1:0] gnt,
  input logic [N_REQ-1:0] accept,
  input logic [3:0]       beat_cnt
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  a_accept_in_gnt: assert property (@(posedge clk) disable iff (rst)
    (accept & ~gnt) == '0);

  a_beat_bound: assert property (@(posedge clk) disable iff (rst)
    beat_cnt <= 4'(MAX_BURST));

endmodule

module sig_bus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       accept,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Round-robin pick: first requester found scanning upward from lw+1,
  // wrapping modulo N_REQ. lw itself is checked last, so a lone requester
  // that just finished its burst is picked again.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [IDX_W-1:0] lw);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = lw;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(lw) + k) % N_REQ);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [N_REQ-1:0]   gnt_r;
  logic [N_REQ-1:0]   gnt_nxt_s;
  logic [IDX_W-1:0]   last_winner_r;
  logic [IDX_W-1:0]   last_winner_nxt_s;
  logic [3:0]         beat_cnt_r;
  logic [3:0]         beat_cnt_nxt_s;
  logic [WIDTH-1:0]   out_data_r;
  logic               out_valid_r;

  logic               slot_free_s;
  logic [N_REQ-1:0]   accept_s;
  logic               any_req_s;
  logic               any_accept_s;
  logic               granted_req_s;
  logic [IDX_W-1:0]   pick_s;
  logic [3:0]         beat_inc_s;
  logic               burst_done_s;
  logic               release_s;
  logic [WIDTH-1:0]   acc_data_s;

  // The output register can take a beat when empty or being drained now.
  assign slot_free_s   = ~out_valid_r | out_ready;
  assign accept_s      = gnt_r & req & {N_REQ{slot_free_s & ~rst}};
  assign any_req_s     = |req;
  assign any_accept_s  = |accept_s;
  assign granted_req_s = |(gnt_r & req);
  assign pick_s        = rr_pick(req, last_winner_r);
  assign beat_inc_s    = beat_cnt_r + {3'b000, any_accept_s};
  assign burst_done_s  = any_accept_s & (beat_inc_s == 4'(MAX_BURST));
  // Grant holder withdrew, or this accept used up its burst allowance.
  assign release_s     = ~granted_req_s | burst_done_s;

  // Select the accepted slice; accept is one-hot so an AND-OR mux suffices.
  always_comb begin
    acc_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      acc_data_s = acc_data_s | (req_data[i*WIDTH +: WIDTH] & {WIDTH{accept_s[i]}});
    end
  end

  // Arbitration FSM next-state: grant, last winner and burst counter.
  always_comb begin
    state_nxt_s       = state_r;
    gnt_nxt_s         = gnt_r;
    last_winner_nxt_s = last_winner_r;
    beat_cnt_nxt_s    = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          gnt_nxt_s         = to_onehot(pick_s);
          last_winner_nxt_s = pick_s;
          beat_cnt_nxt_s    = 4'd0;
          state_nxt_s       = GRANT;
        end else begin
          gnt_nxt_s   = '0;
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          // Re-arbitrate on the releasing edge; last_winner already holds
          // the outgoing grantee so it naturally gets lowest priority.
          if (any_req_s) begin
            gnt_nxt_s         = to_onehot(pick_s);
            last_winner_nxt_s = pick_s;
            beat_cnt_nxt_s    = 4'd0;
            state_nxt_s       = GRANT;
          end else begin
            gnt_nxt_s      = '0;
            beat_cnt_nxt_s = 4'd0;
            state_nxt_s    = IDLE;
          end
        end else begin
          beat_cnt_nxt_s = beat_inc_s;
        end
      end
      default: begin
        gnt_nxt_s      = '0;
        beat_cnt_nxt_s = 4'd0;
        state_nxt_s    = IDLE;
      end
    endcase
  end

  // Arbitration FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      gnt_r         <= '0;
      last_winner_r <= IDX_W'(N_REQ - 1);
      beat_cnt_r    <= 4'd0;
    end else begin
      state_r       <= state_nxt_s;
      gnt_r         <= gnt_nxt_s;
      last_winner_r <= last_winner_nxt_s;
      beat_cnt_r    <= beat_cnt_nxt_s;
    end
  end

  // Output stage: load on accept, clear valid when drained, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (any_accept_s) begin
      out_data_r  <= acc_data_s;
      out_valid_r <= 1'b1;
    end else if (out_ready && out_valid_r) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
    end
  end

  assign gnt       = gnt_r;
  assign accept    = accept_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

  sig_bus_arbiter_chk #(
    .N_REQ     (N_REQ),
    .MAX_BURST (MAX_BURST)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .gnt      (gnt_r),
    .accept   (accept_s),
    .beat_cnt (beat_cnt_r)
  );

endmodule
